// File: rtl/phys_free_list_if.sv
// rtl/phys_free_list_if.sv - free-list port bundle: dispatch pop side and commit push lanes
interface phys_free_list_if #(
   parameter int SS         = 2,
   parameter int PR_ENTRIES = 64,
   parameter int ARCH_REGS  = 32
);
   localparam int IW    = $clog2(PR_ENTRIES);
   localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                   pop;
   logic [SS-1:0][IW-1:0]  free_list_regs;
   logic                   fl_empty;
   logic [SS-1:0]          push_valid;
   logic [SS-1:0][IW-1:0]  push_reg;
   logic                   fl_full;
   logic [CW-1:0]          free_count;
   logic                   dup_err;

   modport master (
      output pop, push_valid, push_reg,
      input  free_list_regs, fl_empty, fl_full, free_count, dup_err
   );

   modport slave (
      input  pop, push_valid, push_reg,
      output free_list_regs, fl_empty, fl_full, free_count, dup_err
   );
endinterface

// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - circular FIFO of free physical register indices for rename
// Optional duplicate-free filtering enabled by FREE_LIST_DUP_CHECK_EN.
module phys_free_list #(
   parameter int SS         = 2,
   parameter int PR_ENTRIES = 64,
   parameter int ARCH_REGS  = 32
) (
   input logic               clk,
   input logic               rst,
   phys_free_list_if.slave   fl
);
   localparam int IW    = $clog2(PR_ENTRIES);
   localparam int DEPTH = PR_ENTRIES - ARCH_REGS;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   logic [IW-1:0]          mem [DEPTH];
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [CW-1:0]          count;

   logic                   pop_ok;
   logic [SS-1:0]          push_acc;
   logic [SS-1:0][PW-1:0]  push_idx;
   logic                   push_overflow;
   logic                   lane_dup;
   int                     npush;

`ifdef FREE_LIST_DUP_CHECK_EN
   logic [PR_ENTRIES-1:0]  in_list;
   logic [PR_ENTRIES-1:0]  seen;
   logic                   dup_hit;
   logic                   dup_q;
`endif

   function automatic logic [PW-1:0] wrap(input int v);
      return PW'(v % DEPTH);
   endfunction

   always_comb begin
      for (int k = 0; k < SS; k++)
         fl.free_list_regs[k] = mem[wrap(int'(head) + k)];
   end

   assign pop_ok        = fl.pop && (int'(count) >= SS);
   assign fl.fl_empty   = int'(count) < SS;
   assign fl.fl_full    = (count == CW'(DEPTH));
   assign fl.free_count = count;

   // Capacity uses the post-pop count: popped slots at head are free to be
   // overwritten at the edge because the read side is purely combinational.
   always_comb begin : push_sel
      int n;
      int avail;
      n             = 0;
      avail         = DEPTH - int'(count) + (pop_ok ? SS : 0);
      push_acc      = '0;
      push_idx      = '0;
      push_overflow = 1'b0;
      lane_dup      = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
      dup_hit = 1'b0;
      seen    = in_list;
      if (pop_ok)
         for (int k = 0; k < SS; k++) seen[fl.free_list_regs[k]] = 1'b0;
`endif
      for (int i = 0; i < SS; i++) begin
         push_idx[i] = wrap(int'(tail) + n);
         lane_dup    = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
         lane_dup = seen[fl.push_reg[i]];
`endif
         if (fl.push_valid[i] && fl.push_reg[i] != '0) begin
            if (lane_dup) begin
`ifdef FREE_LIST_DUP_CHECK_EN
               dup_hit = 1'b1;
`endif
            end else if (n >= avail) begin
               push_overflow = 1'b1;
            end else begin
               push_acc[i] = 1'b1;
               n           = n + 1;
`ifdef FREE_LIST_DUP_CHECK_EN
               seen[fl.push_reg[i]] = 1'b1;
`endif
            end
         end
      end
      npush = n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= IW'(ARCH_REGS + i);
         head  <= '0;
         tail  <= '0;
         count <= CW'(DEPTH);
`ifdef FREE_LIST_DUP_CHECK_EN
         in_list <= {{DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};
         dup_q   <= 1'b0;
`endif
      end else begin
         assert (!push_overflow) else $warning("push dropped: free list full");
         for (int i = 0; i < SS; i++)
            if (push_acc[i]) mem[push_idx[i]] <= fl.push_reg[i];
         if (pop_ok) head <= wrap(int'(head) + SS);
         tail  <= wrap(int'(tail) + npush);
         count <= CW'(int'(count) - (pop_ok ? SS : 0) + npush);
`ifdef FREE_LIST_DUP_CHECK_EN
         in_list <= seen;
         if (dup_hit) dup_q <= 1'b1;
`endif
      end
   end

`ifdef FREE_LIST_DUP_CHECK_EN
   assign fl.dup_err = dup_q;
`else
   assign fl.dup_err = 1'b0;
`endif
endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - directed self-checking bench for phys_free_list
module tb_phys_free_list;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   phys_free_list_if #(.SS(2), .PR_ENTRIES(64), .ARCH_REGS(32)) fl_if ();

   phys_free_list #(.SS(2), .PR_ENTRIES(64), .ARCH_REGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .fl  (fl_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push2(input logic v0, input int r0, input logic v1, input int r1);
      fl_if.push_valid  = {v1, v0};
      fl_if.push_reg[0] = 6'(r0);
      fl_if.push_reg[1] = 6'(r1);
   endtask

   task automatic idle();
      fl_if.pop        = 1'b0;
      fl_if.push_valid = '0;
      fl_if.push_reg   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      do_reset();
      chk("rst_count", 32'(fl_if.free_count), 32);
      chk("rst_full",  32'(fl_if.fl_full), 1);
      chk("rst_empty", 32'(fl_if.fl_empty), 0);
      chk("rst_reg0",  32'(fl_if.free_list_regs[0]), 32);
      chk("rst_reg1",  32'(fl_if.free_list_regs[1]), 33);
      chk("rst_dup",   32'(fl_if.dup_err), 0);

      for (int g = 0; g < 16; g++) begin
         chk("drain_reg0", 32'(fl_if.free_list_regs[0]), 32'(32 + 2 * g));
         chk("drain_reg1", 32'(fl_if.free_list_regs[1]), 32'(33 + 2 * g));
         fl_if.pop = 1'b1;
         tick();
         idle();
      end
      chk("drained_count", 32'(fl_if.free_count), 0);
      chk("drained_empty", 32'(fl_if.fl_empty), 1);
      chk("drained_full",  32'(fl_if.fl_full), 0);

      fl_if.pop = 1'b1;
      tick();
      idle();
      chk("empty_pop_count", 32'(fl_if.free_count), 0);

      push2(1, 40, 1, 7);
      tick();
      idle();
      chk("push2_count", 32'(fl_if.free_count), 2);
      chk("push2_empty", 32'(fl_if.fl_empty), 0);
      chk("push2_reg0",  32'(fl_if.free_list_regs[0]), 40);
      chk("push2_reg1",  32'(fl_if.free_list_regs[1]), 7);
      fl_if.pop = 1'b1;
      tick();
      idle();
      chk("pop2_count", 32'(fl_if.free_count), 0);

      push2(0, 0, 1, 9);
      tick();
      idle();
      chk("compact_count", 32'(fl_if.free_count), 1);
      chk("compact_empty", 32'(fl_if.fl_empty), 1);
      chk("compact_reg0",  32'(fl_if.free_list_regs[0]), 9);

      push2(1, 0, 1, 0);
      tick();
      idle();
      chk("x0_count", 32'(fl_if.free_count), 1);

      push2(1, 8, 0, 0);
      tick();
      idle();
      chk("pair_reg0", 32'(fl_if.free_list_regs[0]), 9);
      chk("pair_reg1", 32'(fl_if.free_list_regs[1]), 8);
      fl_if.pop = 1'b1;
      tick();
      idle();

      push2(1, 5, 1, 6);
      tick();
      idle();
      chk("sim_pre_count", 32'(fl_if.free_count), 2);
      fl_if.pop = 1'b1;
      push2(1, 10, 1, 11);
      #1;
      chk("sim_cur_reg0", 32'(fl_if.free_list_regs[0]), 5);
      chk("sim_cur_reg1", 32'(fl_if.free_list_regs[1]), 6);
      tick();
      idle();
      chk("sim_next_reg0", 32'(fl_if.free_list_regs[0]), 10);
      chk("sim_next_reg1", 32'(fl_if.free_list_regs[1]), 11);
      chk("sim_count",     32'(fl_if.free_count), 2);
      fl_if.pop = 1'b1;
      tick();
      idle();
      chk("sim_drain_count", 32'(fl_if.free_count), 0);

      for (int j = 0; j < 16; j++) begin
         push2(1, 2 * j + 1, 1, 2 * j + 2);
         tick();
      end
      idle();
      chk("wrap_fill_count", 32'(fl_if.free_count), 32);
      chk("wrap_fill_full",  32'(fl_if.fl_full), 1);
      for (int g = 0; g < 16; g++) begin
         chk("wrap_reg0", 32'(fl_if.free_list_regs[0]), 32'(2 * g + 1));
         chk("wrap_reg1", 32'(fl_if.free_list_regs[1]), 32'(2 * g + 2));
         fl_if.pop = 1'b1;
         tick();
         idle();
      end
      chk("wrap_end_count", 32'(fl_if.free_count), 0);
      chk("wrap_end_empty", 32'(fl_if.fl_empty), 1);

      do_reset();
      push2(1, 12, 0, 0);
      tick();
      idle();
      chk("ovf_count", 32'(fl_if.free_count), 32);
      chk("ovf_reg0",  32'(fl_if.free_list_regs[0]), 32);
      fl_if.pop = 1'b1;
      tick();
      idle();
      chk("ovf_pop_reg0",  32'(fl_if.free_list_regs[0]), 34);
      chk("ovf_pop_reg1",  32'(fl_if.free_list_regs[1]), 35);
      chk("ovf_pop_count", 32'(fl_if.free_count), 30);

      fl_if.pop = 1'b1;
      push2(1, 20, 1, 21);
      do_reset();
      idle();
      chk("rst_prio_count", 32'(fl_if.free_count), 32);
      chk("rst_prio_reg0",  32'(fl_if.free_list_regs[0]), 32);

      fl_if.pop = 1'b1;
      tick();
      idle();
      push2(1, 33, 0, 0);
      tick();
      idle();
      chk("dup_first_count", 32'(fl_if.free_count), 31);
      chk("dup_first_err",   32'(fl_if.dup_err), 0);
      push2(1, 33, 0, 0);
      tick();
      idle();
`ifdef FREE_LIST_DUP_CHECK_EN
      chk("dup_second_count", 32'(fl_if.free_count), 31);
      chk("dup_second_err",   32'(fl_if.dup_err), 1);
      tick();
      chk("dup_sticky_err",   32'(fl_if.dup_err), 1);
`else
      chk("dup_second_count", 32'(fl_if.free_count), 32);
      chk("dup_second_err",   32'(fl_if.dup_err), 0);
`endif
      do_reset();
      chk("dup_rst_err", 32'(fl_if.dup_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
